// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port arbiter and access sequencer for the 16-bit data memory
`timescale 1ns/1ps
module dmem_arbiter #(
   parameter int ADDR_BITS = 5,
   parameter int ARB_MODE  = 0
) (
   input  logic        clk,
   input  logic        rst_n,

   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [15:0] cpu_addr,
   input  logic [15:0] cpu_wdata,
   output logic        cpu_ack,
   output logic [15:0] cpu_rdata,
   output logic        cpu_err,
   output logic        cpu_stall,

   input  logic        dbg_req,
   input  logic        dbg_we,
   input  logic [15:0] dbg_addr,
   input  logic [15:0] dbg_wdata,
   output logic        dbg_ack,
   output logic [15:0] dbg_rdata,
   output logic        dbg_err,

   output logic        mem_rd,
   output logic        mem_wr,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_wdata,
   input  logic [15:0] mem_rdata
);

   // Address bits above the implemented word range; any one set is a range error.
   localparam logic [15:0] HI_MASK = 16'(~((32'd1 << ADDR_BITS) - 32'd1));

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_WR        = 3'd1,
      S_RD_SETUP  = 3'd2,
      S_RD_STROBE = 3'd3,
      S_DONE      = 3'd4
   } state_t;

   // Port id encoding used for the grant/last-grant registers: 0 = cpu, 1 = dbg.
   state_t      r_state;
   state_t      w_state_nxt;
   logic        r_id;
   logic        r_last_grant;

   logic        r_mem_rd;
   logic        r_mem_wr;
   logic [15:0] r_mem_addr;
   logic [15:0] r_mem_wdata;
   logic        r_cpu_ack;
   logic        r_dbg_ack;
   logic        r_cpu_err;
   logic        r_dbg_err;
   logic [15:0] r_cpu_rdata;
   logic [15:0] r_dbg_rdata;

   logic        w_any;
   logic        w_pick_dbg;
   logic        w_sel_we;
   logic [15:0] w_sel_addr;
   logic [15:0] w_sel_wdata;
   logic        w_range_err;
   logic        w_start;
   logic        w_grant_id;

   logic        w_mem_rd_nxt;
   logic        w_mem_wr_nxt;
   logic [15:0] w_mem_addr_nxt;
   logic [15:0] w_mem_wdata_nxt;
   logic        w_done_nxt;
   logic        w_err_nxt;
   logic        w_cpu_ack_nxt;
   logic        w_dbg_ack_nxt;
   logic        w_cpu_err_nxt;
   logic        w_dbg_err_nxt;
   logic [15:0] w_cpu_rdata_nxt;
   logic [15:0] w_dbg_rdata_nxt;
   logic        w_last_grant_nxt;

   assign w_any = cpu_req | dbg_req;

   // Winner selection and request mux; only meaningful while IDLE samples.
   always_comb begin
      if (ARB_MODE == 1) begin
         w_pick_dbg = dbg_req & ~cpu_req;
      end else begin
         // On a tie the port that did not get the last grant wins.
         w_pick_dbg = dbg_req & (~cpu_req | ~r_last_grant);
      end
      w_sel_we    = w_pick_dbg ? dbg_we    : cpu_we;
      w_sel_addr  = w_pick_dbg ? dbg_addr  : cpu_addr;
      w_sel_wdata = w_pick_dbg ? dbg_wdata : cpu_wdata;
      w_range_err = |(w_sel_addr & HI_MASK);
   end

   assign w_start    = (r_state == S_IDLE) & w_any;
   assign w_grant_id = w_start ? w_pick_dbg : r_id;

   // Next-state logic: out-of-range accesses skip straight to DONE.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_any) begin
               if (w_range_err) begin
                  w_state_nxt = S_DONE;
               end else if (w_sel_we) begin
                  w_state_nxt = S_WR;
               end else begin
                  w_state_nxt = S_RD_SETUP;
               end
            end
         end
         S_WR:        w_state_nxt = S_DONE;
         S_RD_SETUP:  w_state_nxt = S_RD_STROBE;
         S_RD_STROBE: w_state_nxt = S_DONE;
         S_DONE:      w_state_nxt = S_IDLE;
         default:     w_state_nxt = S_IDLE;
      endcase
   end

   // Next values of every registered output, decoded from the next state so the
   // memory controls come straight off flops and never glitch.
   always_comb begin
      w_mem_rd_nxt    = (w_state_nxt == S_RD_STROBE);
      w_mem_wr_nxt    = (w_state_nxt == S_WR);
      w_mem_addr_nxt  = r_mem_addr;
      w_mem_wdata_nxt = r_mem_wdata;
      if (w_start && !w_range_err) begin
         w_mem_addr_nxt = w_sel_addr;
         if (w_sel_we) begin
            w_mem_wdata_nxt = w_sel_wdata;
         end
      end

      w_done_nxt    = (w_state_nxt == S_DONE);
      w_cpu_ack_nxt = w_done_nxt & ~w_grant_id;
      w_dbg_ack_nxt = w_done_nxt &  w_grant_id;

      // DONE is entered directly from IDLE only on a range error.
      w_err_nxt     = w_start & w_range_err;
      w_cpu_err_nxt = w_err_nxt & ~w_grant_id;
      w_dbg_err_nxt = w_err_nxt &  w_grant_id;

      // Read data registers hold between accesses; a range error returns zero.
      w_cpu_rdata_nxt = r_cpu_rdata;
      w_dbg_rdata_nxt = r_dbg_rdata;
      if (w_done_nxt && !w_grant_id) begin
         if (w_err_nxt) begin
            w_cpu_rdata_nxt = '0;
         end else if (r_state == S_RD_STROBE) begin
            w_cpu_rdata_nxt = mem_rdata;
         end
      end
      if (w_done_nxt && w_grant_id) begin
         if (w_err_nxt) begin
            w_dbg_rdata_nxt = '0;
         end else if (r_state == S_RD_STROBE) begin
            w_dbg_rdata_nxt = mem_rdata;
         end
      end

      w_last_grant_nxt = w_start ? w_pick_dbg : r_last_grant;
   end

   // State and output registers; reset aborts any access in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_id         <= 1'b0;
         r_last_grant <= 1'b1;
         r_mem_rd     <= 1'b0;
         r_mem_wr     <= 1'b0;
         r_mem_addr   <= '0;
         r_mem_wdata  <= '0;
         r_cpu_ack    <= 1'b0;
         r_dbg_ack    <= 1'b0;
         r_cpu_err    <= 1'b0;
         r_dbg_err    <= 1'b0;
         r_cpu_rdata  <= '0;
         r_dbg_rdata  <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_id         <= w_grant_id;
         r_last_grant <= w_last_grant_nxt;
         r_mem_rd     <= w_mem_rd_nxt;
         r_mem_wr     <= w_mem_wr_nxt;
         r_mem_addr   <= w_mem_addr_nxt;
         r_mem_wdata  <= w_mem_wdata_nxt;
         r_cpu_ack    <= w_cpu_ack_nxt;
         r_dbg_ack    <= w_dbg_ack_nxt;
         r_cpu_err    <= w_cpu_err_nxt;
         r_dbg_err    <= w_dbg_err_nxt;
         r_cpu_rdata  <= w_cpu_rdata_nxt;
         r_dbg_rdata  <= w_dbg_rdata_nxt;
      end
   end

   assign mem_rd    = r_mem_rd;
   assign mem_wr    = r_mem_wr;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;
   assign cpu_ack   = r_cpu_ack;
   assign cpu_err   = r_cpu_err;
   assign cpu_rdata = r_cpu_rdata;
   assign dbg_ack   = r_dbg_ack;
   assign dbg_err   = r_dbg_err;
   assign dbg_rdata = r_dbg_rdata;

   // The pipeline freezes for as long as its request is outstanding.
   assign cpu_stall = cpu_req & ~r_cpu_ack;

endmodule
